// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types for the pipeline control unit:
//   ctrl_bundle_t : decoded control bits carried from ID through EX/MEM/WB
//   fwd_sel_t     : EX operand source select (register file, WB or MEM result)
//   CTRL_BUBBLE   : all-zero bundle used to insert a NOP into a stage
//   ALUOP_*       : encodings of the decoder's 2-bit ALU op field
package pipe_ctrl_pkg;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;  // LW/SW address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // R/I-type, funct decides
  localparam logic [1:0] ALUOP_LUI    = 2'b11;  // pass immediate

  // Field order fixes the packed layout: alusrc is the MSB, aluop the LSBs.
  typedef struct packed {
    logic       alusrc;
    logic       jaltoreg;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg
// One pipeline stage register holding a control bundle plus a packed group
// of register indices. clr_i loads a bubble (all-zero bundle and indices) and
// takes priority over en_i; with neither asserted the stage holds.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (reset = bubble)
//   en_i, clr_i  : load enable, load-bubble
//   ctrl_i/idx_i : next-stage contents
//   ctrl_o/idx_o : registered contents
module ctrl_stage_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  ctrl_bundle_t     ctrl_i,
  input  logic [IDX_W-1:0] idx_i,
  output ctrl_bundle_t     ctrl_o,
  output logic [IDX_W-1:0] idx_o
);

  ctrl_bundle_t     ctrl_q, ctrl_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    ctrl_d = ctrl_q;
    idx_d  = idx_q;
    if (clr_i) begin
      ctrl_d = CTRL_BUBBLE;
      idx_d  = '0;
    end else if (en_i) begin
      ctrl_d = ctrl_i;
      idx_d  = idx_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= CTRL_BUBBLE;
      idx_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      idx_q  <= idx_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit
// Carries the ID-stage decoded control bundle through the ID/EX, EX/MEM and
// MEM/WB registers, detects load-use hazards, generates stall / IF-ID flush
// with bubble insertion into EX, and drives the EX forwarding selects.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   id_*                  : decoder control bits and register fields in ID
//   ex_branch_taken       : branch/jump resolved taken for the EX instruction
//   stall, flush_ifid     : combinational hazard controls for PC and IF/ID
//   ex/mem/wb_ctrl, *_rs*, *_rd : registered stage contents
//   fwd_a, fwd_b          : EX operand source selects
// Optional build macro PIPE_CTRL_STATS_EN adds saturating 32-bit
// stall_count / flush_count outputs.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_alusrc,
  input  logic                  id_jaltoreg,
  input  logic                  id_memtoreg,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic [1:0]            id_aluop,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush_ifid,
  output ctrl_bundle_t          ex_ctrl,
  output ctrl_bundle_t          mem_ctrl,
  output ctrl_bundle_t          wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output fwd_sel_t              fwd_a,
  output fwd_sel_t              fwd_b
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  ctrl_bundle_t              id_ctrl;
  logic                      load_use;
  logic                      ex_clr;
  logic [3*REG_ADDR_W-1:0]   ex_idx;

  always_comb begin
    id_ctrl          = CTRL_BUBBLE;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.jaltoreg = id_jaltoreg;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.memread  = id_memread;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.branch   = id_branch;
    id_ctrl.aluop    = id_aluop;
  end

  // A load in EX whose destination is a source of the ID instruction cannot
  // forward in time; x0 is never a real dependency.
  assign load_use = ex_ctrl.memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // A taken branch kills the ID instruction anyway, so it overrides a stall.
  assign flush_ifid = ex_branch_taken;
  assign stall      = load_use && !ex_branch_taken;
  assign ex_clr     = load_use || ex_branch_taken;

  ctrl_stage_reg #(.IDX_W(3*REG_ADDR_W)) u_ex (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (1'b1),
    .clr_i  (ex_clr),
    .ctrl_i (id_ctrl),
    .idx_i  ({id_rs1, id_rs2, id_rd}),
    .ctrl_o (ex_ctrl),
    .idx_o  (ex_idx)
  );

  assign {ex_rs1, ex_rs2, ex_rd} = ex_idx;

  // MEM and WB always advance; only EX ever receives a bubble.
  ctrl_stage_reg #(.IDX_W(REG_ADDR_W)) u_mem (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .ctrl_i (ex_ctrl),
    .idx_i  (ex_rd),
    .ctrl_o (mem_ctrl),
    .idx_o  (mem_rd)
  );

  ctrl_stage_reg #(.IDX_W(REG_ADDR_W)) u_wb (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .ctrl_i (mem_ctrl),
    .idx_i  (mem_rd),
    .ctrl_o (wb_ctrl),
    .idx_o  (wb_rd)
  );

  // MEM holds the younger result, so it wins over WB for the same register.
  function automatic fwd_sel_t fwd_pick(
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  wb_rw,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_rw && (m_rd != '0) && (m_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_rw && (w_rd != '0) && (w_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_pick(mem_ctrl.regwrite, mem_rd, wb_ctrl.regwrite, wb_rd, ex_rs1);
  assign fwd_b = fwd_pick(mem_ctrl.regwrite, mem_rd, wb_ctrl.regwrite, wb_rd, ex_rs2);

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (flush_ifid && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/pipeline_ctrl_unit.md
# pipeline_ctrl_unit

Consumer of the main decoder's control outputs in the 5-stage RISC-V pipeline. It carries the decoded control bundle from ID through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards, generates stall, flush and bubble insertion, and drives the EX-stage forwarding selects. It sits between the ID-stage decoder and the EX/MEM/WB datapath muxes.

## Interface
- REG_ADDR_W, 5, register-index width
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all stage registers
- id_alusrc, id_jaltoreg, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoder control bits for the instruction in ID
- id_aluop  in  2  decoder ALU op: 00 LW/SW, 01 branch, 10 R/I-type, 11 LUI
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register fields of the ID instruction
- ex_branch_taken  in  1  datapath branch/jump resolution for the instruction in EX
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  replace IF/ID contents with a NOP at next edge
- ex_ctrl, mem_ctrl, wb_ctrl  out  ctrl_bundle_t  registered control bundles per stage
- ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd  out  REG_ADDR_W  registered register indices
- fwd_a, fwd_b  out  2  EX operand source select (fwd_sel_t)

## Operation
- Bundle: alusrc, jaltoreg, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0].
- Bubble is the all-zero bundle with rs1/rs2/rd = 0.
- Each edge with no stall or flush: ID → EX, EX → MEM, MEM → WB. WB contents are discarded.
- Load-use stall: stall = ex_ctrl.memread & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - On a stall edge, a bubble loads into EX.
  - MEM and WB advance normally.
  - The ID inputs are held by the datapath and re-evaluated next cycle.
- Flush: flush_ifid = ex_branch_taken.
  - On a flush edge, a bubble loads into EX, which kills the ID instruction.
  - The EX instruction still advances to MEM.
- Simultaneous stall and flush: flush wins.
  - stall is forced to 0.
  - EX gets a bubble.
  - IF/ID is flushed.
- fwd_a is evaluated in priority order:
  - MEM (10) if mem_ctrl.regwrite & mem_rd≠0 & mem_rd==ex_rs1;
  - else WB (01) if wb_ctrl.regwrite & wb_rd≠0 & wb_rd==ex_rs1;
  - else RF (00).
- fwd_b uses the same rule with ex_rs2.
- Writes to register x0 never forward and never stall.

## Timing
- Control latency: ID→EX 1 cycle, →MEM 2, →WB 3.
- stall, flush_ifid, fwd_a and fwd_b are combinational from current inputs and registered state, valid within the same cycle.
- Load-use costs exactly one bubble cycle. Stall deasserts in the following cycle because EX then holds the bubble.
- Taken branch costs one flush cycle in this unit. PC redirect is owned by the datapath.
- Reset, asynchronous at any time including mid-stall:
  - all stage registers go to bubble;
  - stall=0, flush_ifid=0 unless ex_branch_taken is driven;
  - fwd_a=fwd_b=00.
  - The first edge after reset deassertion loads ID normally.

## Configuration
- PIPE_CTRL_STATS_EN defined: adds output ports stall_count and flush_count, each 32 bits.
  - Increment on each edge where stall (resp. flush_ifid) is 1.
  - Saturate at 32'hFFFF_FFFF.
  - Cleared by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- pipe_ctrl_pkg holds:
  - ctrl_bundle_t packed struct;
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - CTRL_BUBBLE constant;
  - the ALUOp encodings.
- Sub-module ctrl_stage_reg holds one stage register: bundle plus indices, with inputs clr (load bubble) and en. It is instantiated three times.

## Test plan
- Reset asserted mid-stream with non-zero bundles in all stages → all stage outputs zero immediately, fwd 00, stall 0.
- LW x5 followed by ADD x6,x5,x7 → stall=1 for exactly one cycle, EX bubble, then ADD in EX with fwd_a=01 (WB).
- ADD x5 followed by SUB x8,x5,x5 → no stall, fwd_a=fwd_b=10 (MEM).
- x5 written in both MEM and WB with EX reading x5 → fwd_a=10. Writes to x0 → fwd 00 and no stall on an LW x0 load-use pattern.
- ex_branch_taken=1 in the same cycle as a load-use condition → flush_ifid=1, stall=0, EX bubble next edge, branch bundle reaches MEM.
- PIPE_CTRL_STATS_EN: 3 load-use stalls and 2 taken branches → stall_count=3, flush_count=2. Preloaded counter at max stays at 32'hFFFF_FFFF.
